// File: rtl/gray_sync_pkg.sv
// gray_sync_pkg
// Shared helpers for the Gray-code synchronizer array.
//   bin2gray / gray2bin : width-generic conversions on a zero-extended
//                         GS_MAX_W-bit word (callers cast in and out).
//   popcount_gt1        : true when more than one bit of the word is set.
package gray_sync_pkg;

    localparam int GS_MAX_W = 64;

    typedef logic [GS_MAX_W-1:0] gs_word_t;

    function automatic gs_word_t bin2gray(input gs_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down. Zero-extended upper bits contribute
    // nothing, so the low slice is correct for any narrower width.
    function automatic gs_word_t gray2bin(input gs_word_t g);
        gs_word_t b;
        b[GS_MAX_W-1] = g[GS_MAX_W-1];
        for (int i = GS_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Clearing the lowest set bit leaves a nonzero word only when at least
    // two bits were set.
    function automatic logic popcount_gt1(input gs_word_t x);
        return (x & (x - gs_word_t'(1))) != '0;
    endfunction

endpackage

// File: rtl/gray_sync_chan.sv
// gray_sync_chan
// One channel of the destination-clocked Gray synchronizer: STAGES-deep sync
// chain, one-deep history register, stability filter, commit register and a
// sticky multi-bit-step error flag.
// Ports:
//   clk_dst, rst_n_dst : destination clock, async active-low reset
//   data_in            : asynchronous value (binary or Gray per INPUT_GRAY)
//   err_clr            : synchronous clear of err_multi_bit
//   data_out           : committed binary value (registered)
//   changed            : one-cycle pulse when data_out updates
//   err_multi_bit      : sticky flag for an illegal multi-bit Gray step
module gray_sync_chan
    import gray_sync_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int STAGES        = 2,
    parameter int INPUT_GRAY    = 0,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                  clk_dst,
    input  logic                  rst_n_dst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  changed,
    output logic                  err_multi_bit
);

    logic [DATA_WIDTH-1:0] gray_in;
    logic [DATA_WIDTH-1:0] sync_ff [STAGES];
    logic [DATA_WIDTH-1:0] sync_q;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] held_q;
    logic [DATA_WIDTH-1:0] commit_val;
    logic                  commit;

    generate
        if (INPUT_GRAY != 0) begin : g_gray_in
            assign gray_in = data_in;
        end else begin : g_bin_in
            assign gray_in = DATA_WIDTH'(bin2gray(gs_word_t'(data_in)));
        end
    endgenerate

    always_ff @(posedge clk_dst or negedge rst_n_dst) begin
        if (!rst_n_dst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_ff[i] <= '0;
            end
        end else begin
            sync_ff[0] <= gray_in;
            for (int i = 1; i < STAGES; i++) begin
                sync_ff[i] <= sync_ff[i-1];
            end
        end
    end

    assign sync_q = sync_ff[STAGES-1];

    generate
        if (STABLE_CYCLES > 0) begin : g_filter
            localparam int CNT_W = ($clog2(STABLE_CYCLES + 1) > 1) ?
                                   $clog2(STABLE_CYCLES + 1) : 1;
            localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
            localparam logic [CNT_W:0]   CNT_THR = (CNT_W + 1)'(STABLE_CYCLES);

            logic [CNT_W-1:0] cnt;
            logic             eq;

            assign eq = (sync_q == prev_q);

            always_ff @(posedge clk_dst or negedge rst_n_dst) begin
                if (!rst_n_dst) begin
                    cnt <= '0;
                end else if (!eq) begin
                    cnt <= '0;
                end else if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end

            // cnt+1 counts the equal pair seen this cycle; the extra bit keeps
            // the sum from wrapping at saturation.
            assign commit     = eq && (({1'b0, cnt} + (CNT_W + 1)'(1)) >= CNT_THR)
                                   && (prev_q != held_q);
            assign commit_val = prev_q;
        end else begin : g_nofilter
            assign commit     = (sync_q != held_q);
            assign commit_val = sync_q;
        end
    endgenerate

    always_ff @(posedge clk_dst or negedge rst_n_dst) begin
        if (!rst_n_dst) begin
            prev_q        <= '0;
            held_q        <= '0;
            data_out      <= '0;
            changed       <= 1'b0;
            err_multi_bit <= 1'b0;
        end else begin
            prev_q  <= sync_q;
            changed <= commit;
            if (commit) begin
                held_q   <= commit_val;
                data_out <= DATA_WIDTH'(gray2bin(gs_word_t'(commit_val)));
            end
            // Set has priority over a coincident clear.
            if (popcount_gt1(gs_word_t'(sync_q ^ prev_q))) begin
                err_multi_bit <= 1'b1;
            end else if (err_clr) begin
                err_multi_bit <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gray_sync_array.sv
// gray_sync_array
// Multi-channel Gray-code synchronizer into clk_dst with per-channel
// stability filter, commit strobe and sticky multi-bit-step error.
// Ports:
//   clk_dst, rst_n_dst : destination clock, async active-low reset
//   data_in            : CHANNELS packed slices of DATA_WIDTH bits
//   err_clr            : clears every channel's err_multi_bit
//   data_out           : committed binary values, same packing as data_in
//   changed            : per-channel one-cycle commit pulse
//   err_multi_bit      : per-channel sticky error flag
module gray_sync_array
    import gray_sync_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int STAGES        = 2,
    parameter int INPUT_GRAY    = 0,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                           clk_dst,
    input  logic                           rst_n_dst,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
    input  logic                           err_clr,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
    output logic [CHANNELS-1:0]            changed,
    output logic [CHANNELS-1:0]            err_multi_bit
);

    generate
        if (CHANNELS < 1) begin : g_bad_channels
            $error("gray_sync_array: CHANNELS must be >= 1");
        end
        if (DATA_WIDTH < 2) begin : g_bad_width
            $error("gray_sync_array: DATA_WIDTH must be >= 2");
        end
        if (DATA_WIDTH > GS_MAX_W) begin : g_wide_width
            $error("gray_sync_array: DATA_WIDTH exceeds helper word width");
        end
        if (STAGES < 2) begin : g_bad_stages
            $error("gray_sync_array: STAGES must be >= 2");
        end

        for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
            gray_sync_chan #(
                .DATA_WIDTH    (DATA_WIDTH),
                .STAGES        (STAGES),
                .INPUT_GRAY    (INPUT_GRAY),
                .STABLE_CYCLES (STABLE_CYCLES)
            ) u_chan (
                .clk_dst       (clk_dst),
                .rst_n_dst     (rst_n_dst),
                .data_in       (data_in[c*DATA_WIDTH +: DATA_WIDTH]),
                .err_clr       (err_clr),
                .data_out      (data_out[c*DATA_WIDTH +: DATA_WIDTH]),
                .changed       (changed[c]),
                .err_multi_bit (err_multi_bit[c])
            );
        end
    endgenerate

endmodule

// File: tb/tb_gray_sync_array.sv
// tb_gray_sync_array
// Three instances share clock and reset:
//   0: binary input, STABLE_CYCLES=2   1: Gray input, STABLE_CYCLES=2
//   2: binary input, STABLE_CYCLES=0
// The reference model keeps a per-channel history of sampled Gray values and
// commits a value once the last STABLE_CYCLES+1 samples, seen through the
// STAGES-deep pipeline delay, agree and differ from the last committed value.
module tb_gray_sync_array;

    localparam int NI = 3;
    localparam int NC = 4;
    localparam int DW = 8;
    localparam int ST = 2;

    logic        clk_dst = 1'b0;
    logic        rst_n   = 1'b0;
    logic [31:0] din  [NI];
    logic        clr  [NI];
    logic [31:0] dout [NI];
    logic [3:0]  chg  [NI];
    logic [3:0]  err  [NI];

    int total = 0;
    int bad   = 0;

    always #5 clk_dst = ~clk_dst;

    gray_sync_array #(.CHANNELS(NC), .DATA_WIDTH(DW), .STAGES(ST),
                      .INPUT_GRAY(0), .STABLE_CYCLES(2)) dut_a (
        .clk_dst(clk_dst), .rst_n_dst(rst_n), .data_in(din[0]), .err_clr(clr[0]),
        .data_out(dout[0]), .changed(chg[0]), .err_multi_bit(err[0]));

    gray_sync_array #(.CHANNELS(NC), .DATA_WIDTH(DW), .STAGES(ST),
                      .INPUT_GRAY(1), .STABLE_CYCLES(2)) dut_g (
        .clk_dst(clk_dst), .rst_n_dst(rst_n), .data_in(din[1]), .err_clr(clr[1]),
        .data_out(dout[1]), .changed(chg[1]), .err_multi_bit(err[1]));

    gray_sync_array #(.CHANNELS(NC), .DATA_WIDTH(DW), .STAGES(ST),
                      .INPUT_GRAY(0), .STABLE_CYCLES(0)) dut_z (
        .clk_dst(clk_dst), .rst_n_dst(rst_n), .data_in(din[2]), .err_clr(clr[2]),
        .data_out(dout[2]), .changed(chg[2]), .err_multi_bit(err[2]));

    // ---------------- reference model ----------------
    function automatic int sc_of(input int i);
        return (i == 2) ? 0 : 2;
    endfunction

    function automatic logic [7:0] g2b(input logic [7:0] g);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = ^(g >> k);
        return b;
    endfunction

    logic [7:0]  hist [NI][NC][8];   // hist[..][0] = newest sample
    logic [7:0]  held [NI][NC];
    logic [31:0] exp_out [NI];
    logic [3:0]  exp_chg [NI];
    logic [3:0]  exp_err [NI];
    logic [7:0]  m_raw, m_g, m_cand;
    logic        m_stable;

    always @(posedge clk_dst or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                exp_out[i] = '0;
                exp_chg[i] = '0;
                exp_err[i] = '0;
                for (int c = 0; c < NC; c++) begin
                    held[i][c] = '0;
                    for (int k = 0; k < 8; k++) hist[i][c][k] = '0;
                end
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                for (int c = 0; c < NC; c++) begin
                    m_raw = din[i][c*8 +: 8];
                    m_g   = (i == 1) ? m_raw : (m_raw ^ (m_raw >> 1));
                    for (int k = 7; k > 0; k--) hist[i][c][k] = hist[i][c][k-1];
                    hist[i][c][0] = m_g;
                    m_cand   = hist[i][c][ST];
                    m_stable = 1'b1;
                    for (int k = ST; k <= ST + sc_of(i); k++)
                        if (hist[i][c][k] != m_cand) m_stable = 1'b0;
                    if (m_stable && (m_cand != held[i][c])) begin
                        held[i][c] = m_cand;
                        exp_out[i][c*8 +: 8] = g2b(m_cand);
                        exp_chg[i][c] = 1'b1;
                    end else begin
                        exp_chg[i][c] = 1'b0;
                    end
                    if ($countones(hist[i][c][ST] ^ hist[i][c][ST+1]) > 1)
                        exp_err[i][c] = 1'b1;
                    else if (clr[i])
                        exp_err[i][c] = 1'b0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            expect_eq($sformatf("i%0d_data_out", i), dout[i], exp_out[i]);
            expect_eq($sformatf("i%0d_changed", i), 32'(chg[i]), 32'(exp_chg[i]));
            expect_eq($sformatf("i%0d_err", i), 32'(err[i]), 32'(exp_err[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk_dst);
        @(negedge clk_dst);
        check_all();
    endtask

    int pulses;

    initial begin
        for (int i = 0; i < NI; i++) begin
            din[i] = '0;
            clr[i] = 1'b0;
        end

        // Reset state
        repeat (3) tick();
        for (int i = 0; i < NI; i++) begin
            expect_eq("rst_data_out", dout[i], 32'h0);
            expect_eq("rst_changed", 32'(chg[i]), 32'h0);
            expect_eq("rst_err", 32'(err[i]), 32'h0);
        end

        // Latency: ch0 = 0x05 on the filtered build, 0x2A on the unfiltered one
        din[0] = 32'h0000_0005;
        din[2] = 32'h0000_002A;
        rst_n  = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            expect_eq($sformatf("lat_a_chg_e%0d", e), 32'(chg[0]),
                      (e == 5) ? 32'h1 : 32'h0);
            expect_eq($sformatf("lat_a_out_e%0d", e), dout[0],
                      (e >= 5) ? 32'h05 : 32'h0);
            expect_eq($sformatf("lat_z_chg_e%0d", e), 32'(chg[2]),
                      (e == 3) ? 32'h1 : 32'h0);
            expect_eq($sformatf("lat_z_out_e%0d", e), dout[2],
                      (e >= 3) ? 32'h2A : 32'h0);
        end

        // Binary counter on ch1: 0xFE -> 0xFF -> 0x00
        pulses = 0;
        din[0][15:8] = 8'hFE;
        repeat (8) begin tick(); pulses += int'(chg[0][1]); end
        expect_eq("cnt_fe", 32'(dout[0][15:8]), 32'hFE);
        clr[0] = 1'b1;
        tick(); pulses += int'(chg[0][1]);
        clr[0] = 1'b0;
        expect_eq("cnt_clr_err", 32'(err[0]), 32'h0);
        din[0][15:8] = 8'hFF;
        repeat (8) begin tick(); pulses += int'(chg[0][1]); end
        expect_eq("cnt_ff", 32'(dout[0][15:8]), 32'hFF);
        din[0][15:8] = 8'h00;
        repeat (8) begin tick(); pulses += int'(chg[0][1]); end
        expect_eq("cnt_wrap", 32'(dout[0][15:8]), 32'h00);
        expect_eq("cnt_pulses", 32'(pulses), 32'd3);
        expect_eq("cnt_err1", 32'(err[0][1]), 32'h0);

        // ch2 one-cycle glitch is filtered
        din[0][23:16] = 8'h10;
        repeat (8) tick();
        expect_eq("glitch_pre", 32'(dout[0][23:16]), 32'h10);
        pulses = 0;
        din[0][23:16] = 8'h11;
        tick(); pulses += int'(chg[0][2]);
        din[0][23:16] = 8'h10;
        repeat (8) begin tick(); pulses += int'(chg[0][2]); end
        expect_eq("glitch_pulses", 32'(pulses), 32'd0);
        expect_eq("glitch_out", 32'(dout[0][23:16]), 32'h10);

        // Gray input ch3: two-bit step sets sticky error
        din[1][31:24] = 8'h03;
        repeat (6) tick();
        expect_eq("gerr_set", 32'(err[1][3]), 32'h1);
        repeat (4) tick();
        expect_eq("gerr_sticky", 32'(err[1][3]), 32'h1);
        clr[1] = 1'b1;
        tick();
        clr[1] = 1'b0;
        expect_eq("gerr_clr", 32'(err[1][3]), 32'h0);
        din[1][31:24] = 8'h00;
        tick();
        tick();
        expect_eq("gerr_pre_coinc", 32'(err[1][3]), 32'h0);
        clr[1] = 1'b1;
        tick();
        clr[1] = 1'b0;
        expect_eq("gerr_set_wins", 32'(err[1][3]), 32'h1);

        // Randomized phase against the model
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NI; i++) begin
                for (int c = 0; c < NC; c++) begin
                    case ($urandom_range(0, 7))
                        0: din[i][c*8 +: 8] = 8'($urandom);
                        1: din[i][c*8 +: 8] = din[i][c*8 +: 8] + 8'd1;
                        default: ;
                    endcase
                end
                clr[i] = ($urandom_range(0, 31) == 0);
            end
            tick();
        end
        for (int i = 0; i < NI; i++) clr[i] = 1'b0;

        // Reset mid-filter on ch0 = 0x40
        din[0][7:0] = 8'h40;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            expect_eq("mid_rst_out", dout[i], 32'h0);
            expect_eq("mid_rst_chg", 32'(chg[i]), 32'h0);
            expect_eq("mid_rst_err", 32'(err[i]), 32'h0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            pulses += int'(chg[0][0]);
            if (e == 4) expect_eq("rerun_e4", 32'(dout[0][7:0]), 32'h00);
            if (e == 5) expect_eq("rerun_e5", 32'(dout[0][7:0]), 32'h40);
        end
        expect_eq("rerun_pulses", 32'(pulses), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
